// File: rtl/dmi_jtag_initiator_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmi_jtag_initiator_pkg : DMI/DTM types shared by the JTAG DMI initiator
// Revision: 1.0
// ----------------------------------------------------------------------------
package dmi_jtag_initiator_pkg;

  localparam int DmiScanWidth = 41;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef enum logic [1:0] {
    DTM_SUCCESS = 2'h0,
    DTM_ERR     = 2'h2,
    DTM_BUSY    = 2'h3
  } dtm_op_status_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef struct packed {
    logic [13:0] zero1;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero0;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  typedef enum logic [2:0] {
    Idle      = 3'd0,
    Read      = 3'd1,
    WaitRead  = 3'd2,
    Write     = 3'd3,
    WaitWrite = 3'd4
  } dmi_state_e;

endpackage
`default_nettype wire

// File: rtl/dmi_jtag_initiator_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmi_jtag_initiator_if : DMI request/response channel between DTM and DM
// Revision: 1.0
// ----------------------------------------------------------------------------
interface dmi_jtag_initiator_if
  import dmi_jtag_initiator_pkg::*;
  ();

  dmi_req_t  req;
  logic      req_valid;
  logic      req_ready;
  dmi_resp_t resp;
  logic      resp_valid;
  logic      resp_ready;

  modport master (
    output req, req_valid, resp_ready,
    input  req_ready, resp, resp_valid
  );

  modport slave (
    input  req, req_valid, resp_ready,
    output req_ready, resp, resp_valid
  );

endinterface
`default_nettype wire

// File: rtl/dmi_jtag_initiator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmi_jtag_initiator : turns JTAG DMI scans into DMI requests, tracks sticky status
// Revision: 1.0
// ----------------------------------------------------------------------------
module dmi_jtag_initiator
  import dmi_jtag_initiator_pkg::*;
#(
  parameter logic [2:0] IdleHint   = 3'd1,
  parameter logic [3:0] DtmVersion = 4'h1
) (
  input  wire logic                    clk_i,
  input  wire logic                    rst_i,
  input  wire logic                    capture_dmi_i,
  input  wire logic                    update_dmi_i,
  input  wire logic [DmiScanWidth-1:0] dmi_scan_i,
  output logic      [DmiScanWidth-1:0] dmi_capture_o,
  input  wire logic                    dmireset_i,
  input  wire logic                    dmihardreset_i,
  output dtmcs_t                       dtmcs_o,
  dmi_jtag_initiator_if.master         dmi
);

  dmi_state_e     r_state, w_state_next;
  logic [6:0]     r_addr, w_addr_next;
  logic [31:0]    r_data, w_data_next;
  dtm_op_status_e r_err, w_err_next;
  dtm_op_status_e w_status;
  logic           w_resp_fire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= Idle;
      r_addr  <= '0;
      r_data  <= '0;
      r_err   <= DTM_SUCCESS;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_data  <= w_data_next;
      r_err   <= w_err_next;
    end
  end

  assign w_resp_fire = dmi.resp_valid && (r_state == WaitRead || r_state == WaitWrite);

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_data_next  = r_data;
    w_err_next   = r_err;

    unique case (r_state)
      Idle: begin
        if (update_dmi_i && r_err == DTM_SUCCESS) begin
          w_addr_next = dmi_scan_i[40:34];
          w_data_next = dmi_scan_i[33:2];
          if (dmi_scan_i[1:0] == 2'h1)      w_state_next = Read;
          else if (dmi_scan_i[1:0] == 2'h2) w_state_next = Write;
        end
      end
      Read:      if (dmi.req_ready) w_state_next = WaitRead;
      Write:     if (dmi.req_ready) w_state_next = WaitWrite;
      WaitRead: begin
        if (dmi.resp_valid) begin
          w_state_next = Idle;
          w_data_next  = dmi.resp.data;
        end
      end
      WaitWrite: if (dmi.resp_valid) w_state_next = Idle;
      default:   w_state_next = Idle;
    endcase

    // Only the first problem is recorded; dmireset/hardreset clear it regardless.
    if (r_err == DTM_SUCCESS) begin
      if (r_state != Idle && (capture_dmi_i || update_dmi_i)) w_err_next = DTM_BUSY;
      else if (w_resp_fire && dmi.resp.resp != 2'h0)           w_err_next = DTM_ERR;
    end
    if (dmireset_i || dmihardreset_i) w_err_next = DTM_SUCCESS;

    if (dmihardreset_i) begin
      w_state_next = Idle;
      w_addr_next  = r_addr;
      w_data_next  = r_data;
    end
  end

  always_comb begin
    dmi.req        = '0;
    dmi.req_valid  = 1'b0;
    dmi.resp_ready = 1'b1;
    if (r_state == Read || r_state == Write) begin
      dmi.req.addr   = r_addr;
      dmi.req.op     = (r_state == Read) ? DTM_READ : DTM_WRITE;
      dmi.req.data   = r_data;
      dmi.req_valid  = 1'b1;
      dmi.resp_ready = 1'b0;
    end
  end

  assign w_status      = (r_state != Idle) ? DTM_BUSY : r_err;
  assign dmi_capture_o = {r_addr, r_data, w_status};

  always_comb begin
    dtmcs_o         = '0;
    dtmcs_o.idle    = IdleHint;
    dtmcs_o.dmistat = w_status;
    dtmcs_o.abits   = 6'd7;
    dtmcs_o.version = DtmVersion;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmi_jtag_initiator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dmi_jtag_initiator : directed self-checking bench for dmi_jtag_initiator
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_dmi_jtag_initiator;
  import dmi_jtag_initiator_pkg::*;

  localparam logic [31:0] DTMCS_IDLE = 32'h0000_1071;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        capture_dmi = 1'b0;
  logic        update_dmi = 1'b0;
  logic        dmireset = 1'b0;
  logic        dmihardreset = 1'b0;
  logic [40:0] scan = '0;
  logic [40:0] cap;
  dtmcs_t      dtmcs;

  int n_vec = 0;
  int n_err = 0;

  dmi_jtag_initiator_if dmi_if ();

  dmi_jtag_initiator dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .capture_dmi_i  (capture_dmi),
    .update_dmi_i   (update_dmi),
    .dmi_scan_i     (scan),
    .dmi_capture_o  (cap),
    .dmireset_i     (dmireset),
    .dmihardreset_i (dmihardreset),
    .dtmcs_o        (dtmcs),
    .dmi            (dmi_if.master)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [40:0] mk_scan(input logic [6:0] a, input logic [31:0] d,
                                          input logic [1:0] op);
    return {a, d, op};
  endfunction

  task automatic pulse_update(input logic [40:0] s);
    scan       = s;
    update_dmi = 1'b1;
    tick();
    update_dmi = 1'b0;
  endtask

  task automatic send_resp(input logic [31:0] d, input logic [1:0] r);
    dmi_if.resp       = {d, r};
    dmi_if.resp_valid = 1'b1;
    tick();
    dmi_if.resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    dmi_if.req_ready  = 1'b0;
    dmi_if.resp       = '0;
    dmi_if.resp_valid = 1'b0;

    // reset state
    tick();
    tick();
    check_vec("rst_valid", 64'(dmi_if.req_valid), 64'h0);
    check_vec("rst_req", 64'(dmi_if.req), 64'h0);
    check_vec("rst_capture", 64'(cap), 64'h0);
    check_vec("rst_dtmcs", 64'(dtmcs), 64'(DTMCS_IDLE));
    rst = 1'b0;
    tick();

    // write 0x10 <- 1, ready already high
    dmi_if.req_ready = 1'b1;
    pulse_update(mk_scan(7'h10, 32'h1, 2'h2));
    check_vec("wr_valid", 64'(dmi_if.req_valid), 64'h1);
    check_vec("wr_req", 64'(dmi_if.req), 64'({7'h10, 2'h2, 32'h1}));
    check_vec("wr_busy_status", 64'(cap[1:0]), 64'h3);
    check_vec("wr_resp_ready_low", 64'(dmi_if.resp_ready), 64'h0);
    tick();
    dmi_if.req_ready = 1'b0;
    check_vec("wr_valid_drop", 64'(dmi_if.req_valid), 64'h0);
    check_vec("wr_resp_ready", 64'(dmi_if.resp_ready), 64'h1);
    send_resp(32'hdead_beef, 2'h0);
    check_vec("wr_capture", 64'(cap), 64'({7'h10, 32'h1, 2'h0}));
    check_vec("wr_dtmcs", 64'(dtmcs), 64'(DTMCS_IDLE));

    // read 0x11, response a few cycles later
    pulse_update(mk_scan(7'h11, 32'h0, 2'h1));
    check_vec("rd_req", 64'(dmi_if.req), 64'({7'h11, 2'h1, 32'h0}));
    dmi_if.req_ready = 1'b1;
    tick();
    dmi_if.req_ready = 1'b0;
    tick();
    tick();
    send_resp(32'h0040_3382, 2'h0);
    check_vec("rd_capture", 64'(cap), 64'({7'h11, 32'h0040_3382, 2'h0}));

    // capture during WaitRead -> sticky busy
    pulse_update(mk_scan(7'h12, 32'h0, 2'h1));
    dmi_if.req_ready = 1'b1;
    tick();
    dmi_if.req_ready = 1'b0;
    capture_dmi = 1'b1;
    check_vec("busy_cap_status", 64'(cap[1:0]), 64'h3);
    tick();
    capture_dmi = 1'b0;
    repeat (8) tick();
    send_resp(32'h55, 2'h0);
    check_vec("busy_sticky_cap", 64'(cap), 64'({7'h12, 32'h55, 2'h3}));
    check_vec("busy_dmistat", 64'(dtmcs.dmistat), 64'h3);
    pulse_update(mk_scan(7'h13, 32'h99, 2'h1));
    check_vec("busy_upd_ignored", 64'(dmi_if.req_valid), 64'h0);
    tick();
    check_vec("busy_no_latch", 64'(cap), 64'({7'h12, 32'h55, 2'h3}));
    dmireset = 1'b1;
    tick();
    dmireset = 1'b0;
    check_vec("busy_cleared", 64'(dtmcs.dmistat), 64'h0);

    // error response on read
    dmi_if.req_ready = 1'b1;
    pulse_update(mk_scan(7'h14, 32'h0, 2'h1));
    tick();
    dmi_if.req_ready = 1'b0;
    send_resp(32'habc, 2'h2);
    check_vec("err_capture", 64'(cap), 64'({7'h14, 32'habc, 2'h2}));
    pulse_update(mk_scan(7'h15, 32'h0, 2'h1));
    check_vec("err_upd_ignored", 64'(dmi_if.req_valid), 64'h0);
    check_vec("err_sticky", 64'(cap[1:0]), 64'h2);
    dmireset = 1'b1;
    tick();
    dmireset = 1'b0;
    pulse_update(mk_scan(7'h16, 32'h0, 2'h1));
    check_vec("err_reread_req", 64'(dmi_if.req), 64'({7'h16, 2'h1, 32'h0}));
    dmi_if.req_ready = 1'b1;
    tick();
    dmi_if.req_ready = 1'b0;
    send_resp(32'h77, 2'h0);
    check_vec("err_reread_cap", 64'(cap), 64'({7'h16, 32'h77, 2'h0}));

    // stalled request then hard reset
    pulse_update(mk_scan(7'h20, 32'hcafe_f00d, 2'h2));
    for (int i = 0; i < 3; i++) begin
      check_vec("stall_valid", 64'(dmi_if.req_valid), 64'h1);
      check_vec("stall_req", 64'(dmi_if.req), 64'({7'h20, 2'h2, 32'hcafe_f00d}));
      if (i < 2) tick();
    end
    dmihardreset = 1'b1;
    tick();
    dmihardreset = 1'b0;
    check_vec("hr_valid", 64'(dmi_if.req_valid), 64'h0);
    check_vec("hr_capture", 64'(cap), 64'({7'h20, 32'hcafe_f00d, 2'h0}));
    send_resp(32'h1, 2'h2);
    check_vec("hr_drain_cap", 64'(cap), 64'({7'h20, 32'hcafe_f00d, 2'h0}));
    check_vec("hr_drain_valid", 64'(dmi_if.req_valid), 64'h0);

    // async reset mid-write
    pulse_update(mk_scan(7'h30, 32'h1234, 2'h2));
    check_vec("ar_valid_pre", 64'(dmi_if.req_valid), 64'h1);
    rst = 1'b1;
    #1;
    check_vec("ar_valid_async", 64'(dmi_if.req_valid), 64'h0);
    check_vec("ar_req_async", 64'(dmi_if.req), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    check_vec("ar_capture", 64'(cap), 64'h0);
    check_vec("ar_dtmcs", 64'(dtmcs), 64'(DTMCS_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
